// File: rtl/ndn_spi_slave_port.sv
// NDN serial link slave: independent RX (mosi) and TX (miso) framers, one bit per clk.
// Optional stop-bit check on RX is enabled by defining NDN_SPI_FRAME_CHECK_EN.
module ndn_spi_slave_port (
    input  logic         clk,
    input  logic         rst,
    input  logic         cs,
    input  logic         mosi,
    output logic         miso,
    output logic         rx_valid,
    output logic         rx_err,
    output logic [7:0]   rx_meta,
    output logic [63:0]  rx_prefix,
    output logic [255:0] rx_data,
    input  logic         tx_valid,
    output logic         tx_ready,
    input  logic [7:0]   tx_meta,
    input  logic [63:0]  tx_prefix,
    input  logic [255:0] tx_data,
    output logic         tx_done
);

    typedef enum logic [2:0] {
        RxIdle,
        RxMeta,
        RxPrefix,
        RxData,
        RxStop
    } rx_state_t;

    typedef enum logic [2:0] {
        TxIdle,
        TxStart,
        TxMeta,
        TxPrefix,
        TxData,
        TxStop
    } tx_state_t;

    rx_state_t    rx_state;
    logic [2:0]   rx_meta_cnt;
    logic [5:0]   rx_prefix_cnt;
    logic [7:0]   rx_data_cnt;
    logic [7:0]   rx_meta_sh;
    logic [63:0]  rx_prefix_sh;
    logic [255:0] rx_data_sh;

    tx_state_t    tx_state;
    logic [2:0]   tx_meta_cnt;
    logic [5:0]   tx_prefix_cnt;
    logic [7:0]   tx_data_cnt;
    logic [7:0]   tx_meta_sv;
    logic [63:0]  tx_prefix_sv;
    logic [255:0] tx_data_sv;
    logic         tx_interest;

    logic         stop_ok;

`ifdef NDN_SPI_FRAME_CHECK_EN
    assign stop_ok = mosi;
`else
    assign stop_ok = 1'b1;
`endif

    // Receive framer: shadow registers fill bit by bit, outputs only move at the stop edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state      <= RxIdle;
            rx_meta_cnt   <= 3'd0;
            rx_prefix_cnt <= 6'd0;
            rx_data_cnt   <= 8'd0;
            rx_meta_sh    <= 8'd0;
            rx_prefix_sh  <= 64'd0;
            rx_data_sh    <= 256'd0;
            rx_valid      <= 1'b0;
            rx_err        <= 1'b0;
            rx_meta       <= 8'd0;
            rx_prefix     <= 64'd0;
            rx_data       <= 256'd0;
        end else begin
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            if (cs) begin
                rx_state <= RxIdle;
            end else begin
                unique case (rx_state)
                    RxIdle: begin
                        if (!mosi) begin
                            rx_state    <= RxMeta;
                            rx_meta_cnt <= 3'd7;
                        end
                    end
                    RxMeta: begin
                        rx_meta_sh <= {rx_meta_sh[6:0], mosi};
                        if (rx_meta_cnt == 3'd0) begin
                            rx_state      <= RxPrefix;
                            rx_prefix_cnt <= 6'd63;
                        end else begin
                            rx_meta_cnt <= rx_meta_cnt - 3'd1;
                        end
                    end
                    RxPrefix: begin
                        rx_prefix_sh <= {rx_prefix_sh[62:0], mosi};
                        if (rx_prefix_cnt == 6'd0) begin
                            if (rx_meta_sh[6]) begin
                                rx_state <= RxStop;
                            end else begin
                                rx_state    <= RxData;
                                rx_data_cnt <= 8'd255;
                            end
                        end else begin
                            rx_prefix_cnt <= rx_prefix_cnt - 6'd1;
                        end
                    end
                    RxData: begin
                        rx_data_sh <= {rx_data_sh[254:0], mosi};
                        if (rx_data_cnt == 8'd0) begin
                            rx_state <= RxStop;
                        end else begin
                            rx_data_cnt <= rx_data_cnt - 8'd1;
                        end
                    end
                    RxStop: begin
                        rx_state <= RxIdle;
                        if (stop_ok) begin
                            rx_valid  <= 1'b1;
                            rx_meta   <= rx_meta_sh;
                            rx_prefix <= rx_prefix_sh;
                            // Interest packets carry no data; keep the last data payload.
                            if (!rx_meta_sh[6]) begin
                                rx_data <= rx_data_sh;
                            end
                        end else begin
                            rx_err <= 1'b1;
                        end
                    end
                    default: rx_state <= RxIdle;
                endcase
            end
        end
    end

    // Transmit framer: save registers shift left, miso always carries the current MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state      <= TxIdle;
            tx_meta_cnt   <= 3'd0;
            tx_prefix_cnt <= 6'd0;
            tx_data_cnt   <= 8'd0;
            tx_meta_sv    <= 8'd0;
            tx_prefix_sv  <= 64'd0;
            tx_data_sv    <= 256'd0;
            tx_interest   <= 1'b0;
            miso          <= 1'b1;
            tx_ready      <= 1'b1;
            tx_done       <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (cs) begin
                tx_state <= TxIdle;
                miso     <= 1'b1;
                tx_ready <= 1'b1;
            end else begin
                unique case (tx_state)
                    TxIdle: begin
                        miso     <= 1'b1;
                        tx_ready <= 1'b1;
                        if (tx_valid && tx_ready) begin
                            tx_meta_sv   <= tx_meta;
                            tx_prefix_sv <= tx_prefix;
                            tx_data_sv   <= tx_data;
                            tx_interest  <= tx_meta[6];
                            tx_state     <= TxStart;
                            miso         <= 1'b0;
                            tx_ready     <= 1'b0;
                        end
                    end
                    TxStart: begin
                        miso        <= tx_meta_sv[7];
                        tx_meta_sv  <= {tx_meta_sv[6:0], 1'b0};
                        tx_meta_cnt <= 3'd7;
                        tx_state    <= TxMeta;
                    end
                    TxMeta: begin
                        if (tx_meta_cnt == 3'd0) begin
                            miso          <= tx_prefix_sv[63];
                            tx_prefix_sv  <= {tx_prefix_sv[62:0], 1'b0};
                            tx_prefix_cnt <= 6'd63;
                            tx_state      <= TxPrefix;
                        end else begin
                            miso        <= tx_meta_sv[7];
                            tx_meta_sv  <= {tx_meta_sv[6:0], 1'b0};
                            tx_meta_cnt <= tx_meta_cnt - 3'd1;
                        end
                    end
                    TxPrefix: begin
                        if (tx_prefix_cnt == 6'd0) begin
                            if (tx_interest) begin
                                miso     <= 1'b1;
                                tx_state <= TxStop;
                            end else begin
                                miso        <= tx_data_sv[255];
                                tx_data_sv  <= {tx_data_sv[254:0], 1'b0};
                                tx_data_cnt <= 8'd255;
                                tx_state    <= TxData;
                            end
                        end else begin
                            miso          <= tx_prefix_sv[63];
                            tx_prefix_sv  <= {tx_prefix_sv[62:0], 1'b0};
                            tx_prefix_cnt <= tx_prefix_cnt - 6'd1;
                        end
                    end
                    TxData: begin
                        if (tx_data_cnt == 8'd0) begin
                            miso     <= 1'b1;
                            tx_state <= TxStop;
                        end else begin
                            miso        <= tx_data_sv[255];
                            tx_data_sv  <= {tx_data_sv[254:0], 1'b0};
                            tx_data_cnt <= tx_data_cnt - 8'd1;
                        end
                    end
                    TxStop: begin
                        miso     <= 1'b1;
                        tx_done  <= 1'b1;
                        tx_ready <= 1'b1;
                        tx_state <= TxIdle;
                    end
                    default: begin
                        miso     <= 1'b1;
                        tx_ready <= 1'b1;
                        tx_state <= TxIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ndn_spi_slave_port.sv
// Randomized bench for ndn_spi_slave_port: frame-level reference model, per-bit miso checks.
module tb_ndn_spi_slave_port;

`ifdef NDN_SPI_FRAME_CHECK_EN
    localparam bit FrameCheck = 1'b1;
`else
    localparam bit FrameCheck = 1'b0;
`endif

    typedef bit frame_t [0:329];

    typedef struct {
        int unsigned  cyc;
        bit           err;
        logic [7:0]   meta;
        logic [63:0]  prefix;
        logic [255:0] data;
    } rx_ev_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         cs;
    logic         mosi;
    logic         miso;
    logic         rx_valid;
    logic         rx_err;
    logic [7:0]   rx_meta;
    logic [63:0]  rx_prefix;
    logic [255:0] rx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [7:0]   tx_meta;
    logic [63:0]  tx_prefix;
    logic [255:0] tx_data;
    logic         tx_done;

    int unsigned  cyc = 0;
    int           n_tests = 0;
    int           n_fail = 0;

    // Reference model: last good packet and expected pulse events.
    logic [7:0]   mdl_meta = '0;
    logic [63:0]  mdl_prefix = '0;
    logic [255:0] mdl_data = '0;
    rx_ev_t       exp_q[$];
    rx_ev_t       obs_q[$];

    ndn_spi_slave_port dut (
        .clk       (clk),
        .rst       (rst),
        .cs        (cs),
        .mosi      (mosi),
        .miso      (miso),
        .rx_valid  (rx_valid),
        .rx_err    (rx_err),
        .rx_meta   (rx_meta),
        .rx_prefix (rx_prefix),
        .rx_data   (rx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_meta   (tx_meta),
        .tx_prefix (tx_prefix),
        .tx_data   (tx_data),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) obs_q.push_back('{cyc, 1'b0, rx_meta, rx_prefix, rx_data});
        if (rx_err)   obs_q.push_back('{cyc, 1'b1, 8'd0, 64'd0, 256'd0});
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Line image of one packet: start, meta, prefix, data (data packets only), stop.
    function automatic frame_t frame_bits(input logic [7:0] m, input logic [63:0] p,
                                          input logic [255:0] d, input bit stop);
        frame_t f;
        for (int i = 0; i < 330; i++) f[i] = 1'b1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1 + i] = m[7 - i];
        for (int i = 0; i < 64; i++) f[9 + i] = p[63 - i];
        if (m[6]) begin
            f[73] = stop;
        end else begin
            for (int i = 0; i < 256; i++) f[73 + i] = d[255 - i];
            f[329] = stop;
        end
        return f;
    endfunction

    task automatic rx_frame(input logic [7:0] m, input logic [63:0] p, input logic [255:0] d,
                            input bit stop, input int abort_at);
        frame_t f;
        int     n;
        f = frame_bits(m, p, d, stop);
        n = m[6] ? 74 : 330;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == abort_at) begin
                cs   = 1'b1;
                mosi = 1'b1;
                @(negedge clk);
                cs = 1'b0;
                return;
            end
            mosi = f[i];
        end
        // Stop bit was just driven; the pulse shows in the cycle after that edge.
        if (FrameCheck && !stop) begin
            exp_q.push_back('{cyc + 1, 1'b1, 8'd0, 64'd0, 256'd0});
        end else begin
            mdl_meta   = m;
            mdl_prefix = p;
            if (!m[6]) mdl_data = d;
            exp_q.push_back('{cyc + 1, 1'b0, mdl_meta, mdl_prefix, mdl_data});
        end
    endtask

    task automatic rx_compare(input string tag);
        rx_ev_t e;
        rx_ev_t o;
        @(negedge clk);
        mosi = 1'b1;
        repeat (2) @(negedge clk);
        check({tag, "_events"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check({tag, "_cycle"}, o.cyc, e.cyc);
            check({tag, "_kind"}, o.err, e.err);
            if (!e.err) begin
                check({tag, "_meta"}, o.meta, e.meta);
                check({tag, "_prefix"}, o.prefix, e.prefix);
                check({tag, "_data"}, o.data, e.data);
            end
        end
        exp_q.delete();
        obs_q.delete();
        check({tag, "_hold_meta"}, rx_meta, mdl_meta);
        check({tag, "_hold_prefix"}, rx_prefix, mdl_prefix);
        check({tag, "_hold_data"}, rx_data, mdl_data);
    endtask

    task automatic tx_send(input logic [7:0] m, input logic [63:0] p, input logic [255:0] d,
                           input int abort_at);
        frame_t f;
        int     n;
        int     w;
        int     done_seen;
        f = frame_bits(m, p, d, 1'b1);
        n = m[6] ? 74 : 330;
        w = 0;
        done_seen = 0;
        @(negedge clk);
        while (!tx_ready && w < 400) begin
            @(negedge clk);
            w++;
        end
        check("tx_ready_wait", (w < 400), 1);
        if (w >= 400) return;
        tx_valid  = 1'b1;
        tx_meta   = m;
        tx_prefix = p;
        tx_data   = d;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k == 0) begin
                tx_valid  = 1'b0;
                tx_meta   = 8'($urandom);
                tx_prefix = {$urandom, $urandom};
                tx_data   = rnd256();
                check("tx_ready_busy", tx_ready, 0);
            end
            if (tx_done) done_seen++;
            if (abort_at > 0 && k == abort_at) begin
                check("tx_abort_miso", miso, 1);
                check("tx_abort_ready", tx_ready, 1);
                cs = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    if (tx_done) done_seen++;
                end
                check("tx_abort_no_done", done_seen, 0);
                return;
            end
            check("tx_miso_bit", miso, f[k]);
            if (abort_at > 0 && k == abort_at - 1) cs = 1'b1;
        end
        check("tx_no_early_done", done_seen, 0);
        @(negedge clk);
        check("tx_done", tx_done, 1);
        check("tx_ready_after", tx_ready, 1);
        check("tx_idle_miso", miso, 1);
        @(negedge clk);
        check("tx_done_pulse", tx_done, 0);
    endtask

    initial begin
        logic [255:0] pat;
        frame_t       f;
        int           stray;

        rst = 1'b1;
        cs = 1'b0;
        mosi = 1'b1;
        tx_valid = 1'b0;
        tx_meta = '0;
        tx_prefix = '0;
        tx_data = '0;
        repeat (3) @(negedge clk);
        check("rst_miso", miso, 1);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_err", rx_err, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_rx_meta", rx_meta, 0);
        check("rst_rx_prefix", rx_prefix, 0);
        check("rst_rx_data", rx_data, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        pat = {32{8'hA5}};
        pat[255] = 1'b1;
        pat[0] = 1'b1;

        rx_frame(8'h48, 64'h0123456789ABCDEF, 256'd0, 1'b1, -1);
        rx_compare("rx_interest");

        rx_frame(8'h08, 64'hFEDCBA9876543210, pat, 1'b1, -1);
        rx_frame(8'h48, {$urandom, $urandom}, rnd256(), 1'b1, -1);
        rx_compare("rx_data_b2b");

        tx_send(8'h48, 64'h0123456789ABCDEF, rnd256(), -1);
        tx_send(8'h08, 64'hFEDCBA9876543210, pat, -1);

        rx_frame(8'h08, {$urandom, $urandom}, rnd256(), 1'b1, 30);
        rx_compare("rx_cs_abort");
        tx_send(8'h08, {$urandom, $urandom}, rnd256(), 30);

        rx_frame(8'h0C, {$urandom, $urandom}, rnd256(), 1'b0, -1);
        rx_compare("rx_stop_zero");
        rx_frame(8'h4A, {$urandom, $urandom}, rnd256(), 1'b0, -1);
        rx_compare("rx_stop_zero_int");

        for (int it = 0; it < 6; it++) begin
            fork
                rx_frame(8'($urandom), {$urandom, $urandom}, rnd256(), 1'b1, -1);
                tx_send(8'($urandom), {$urandom, $urandom}, rnd256(), -1);
            join
            rx_compare("rx_random");
        end

        // Asynchronous reset in the middle of an RX packet and a TX packet.
        f = frame_bits(8'h08, {$urandom, $urandom}, rnd256(), 1'b1);
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            mosi = f[i];
            tx_valid = (i == 0);
            tx_meta = 8'h08;
            tx_prefix = {$urandom, $urandom};
            tx_data = rnd256();
            @(negedge clk);
        end
        tx_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_mid_miso", miso, 1);
        check("rst_mid_tx_ready", tx_ready, 1);
        check("rst_mid_rx_valid", rx_valid, 0);
        check("rst_mid_rx_err", rx_err, 0);
        check("rst_mid_tx_done", tx_done, 0);
        check("rst_mid_rx_meta", rx_meta, 0);
        check("rst_mid_rx_prefix", rx_prefix, 0);
        check("rst_mid_rx_data", rx_data, 0);
        mdl_meta = '0;
        mdl_prefix = '0;
        mdl_data = '0;
        @(negedge clk);
        mosi = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        stray = 0;
        repeat (8) begin
            @(negedge clk);
            if (tx_done) stray++;
        end
        check("rst_mid_no_done", stray, 0);
        rx_compare("rx_after_rst");

        rx_frame(8'($urandom), {$urandom, $urandom}, rnd256(), 1'b1, -1);
        rx_compare("rx_recover");
        tx_send(8'($urandom), {$urandom, $urandom}, rnd256(), -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
